// File: rtl/ram_client_ctrl.sv
// Initiator-side sequencer for the ram_interface_wrapper DDR user port: single-word requests in, one response out.
// Optional statistics counters are built when RAM_CLIENT_STATS_EN is defined; otherwise stat_* are tied to 0.
module ram_client_ctrl #(
    parameter  int unsigned DATA_BYTE_WIDTH = 2,
    parameter  int unsigned RD_TIMEOUT      = 255,
    localparam int unsigned DW              = 8 * DATA_BYTE_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [25:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          busy,
    output logic [25:0]   ram_address,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_write_enable,
    output logic          ram_read_request,
    output logic          ram_read_ack,
    input  logic [DW-1:0] ram_data_out,
    input  logic          ram_rdy,
    input  logic          ram_rd_data_pres,
    input  logic [25:0]   ram_max_address,
    output logic [15:0]   stat_writes,
    output logic [15:0]   stat_reads,
    output logic [15:0]   stat_timeouts
);

    localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        INIT, IDLE, WRITE, RD_CMD, RD_WAIT, RD_POP, FLUSH, RESP
    } state_t;

    state_t     state;
    logic [7:0] tmo_cnt;

    // Sequencer; busy/req_ready are set on the transition so they track the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= INIT;
            tmo_cnt          <= 8'd0;
            req_ready        <= 1'b0;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            resp_err         <= 1'b0;
            busy             <= 1'b0;
            ram_address      <= '0;
            ram_data_in      <= '0;
            ram_write_enable <= 1'b0;
            ram_read_request <= 1'b0;
            ram_read_ack     <= 1'b0;
        end else begin
            ram_write_enable <= 1'b0;
            ram_read_request <= 1'b0;
            ram_read_ack     <= 1'b0;
            resp_valid       <= 1'b0;
            req_ready        <= 1'b0;
            busy             <= 1'b1;
            case (state)
                INIT: begin
                    if (ram_rdy) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= !ram_rd_data_pres;
                    end
                end
                IDLE: begin
                    if (!ram_rdy) begin
                        state <= INIT;
                    end else if (ram_rd_data_pres) begin
                        state        <= FLUSH;
                        ram_read_ack <= 1'b1;
                    end else if (req_valid && req_ready) begin
                        ram_address <= req_addr;
                        ram_data_in <= req_wdata;
                        if (req_addr > ram_max_address) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write) begin
                            state            <= WRITE;
                            ram_write_enable <= 1'b1;
                        end else begin
                            state            <= RD_CMD;
                            ram_read_request <= 1'b1;
                        end
                    end else begin
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                RD_CMD: begin
                    state   <= RD_WAIT;
                    tmo_cnt <= 8'd0;
                end
                RD_WAIT: begin
                    // Data arriving on the last allowed cycle still wins over the timeout.
                    if (ram_rd_data_pres) begin
                        state        <= RD_POP;
                        ram_read_ack <= 1'b1;
                        resp_rdata   <= ram_data_out;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RD_POP: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                end
                FLUSH, RESP: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= ram_rdy && !ram_rd_data_pres;
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef RAM_CLIENT_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_writes   <= 16'd0;
            stat_reads    <= 16'd0;
            stat_timeouts <= 16'd0;
        end else begin
            if (state == WRITE && stat_writes != 16'hFFFF)
                stat_writes <= stat_writes + 16'd1;
            if (state == RD_POP && stat_reads != 16'hFFFF)
                stat_reads <= stat_reads + 16'd1;
            if (state == RD_WAIT && !ram_rd_data_pres && tmo_cnt == TMO_LAST
                && stat_timeouts != 16'hFFFF)
                stat_timeouts <= stat_timeouts + 16'd1;
        end
    end
`else
    assign stat_writes   = 16'd0;
    assign stat_reads    = 16'd0;
    assign stat_timeouts = 16'd0;
`endif

endmodule

// File: tb/tb_ram_client_ctrl.sv
// Scoreboard bench for ram_client_ctrl: a wrapper model answers reads after a chosen delay,
// a reference memory predicts every response and RAM strobe, and a monitor checks them.
module tb_ram_client_ctrl;

    localparam int          DW       = 16;
    localparam int          RDT      = 8;
    localparam logic [25:0] MAX_ADDR = 26'h3FF;
    localparam int          NEVER    = 0;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [25:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_err, busy;
    logic [DW-1:0] resp_rdata;
    logic [25:0]   ram_address;
    logic [DW-1:0] ram_data_in, ram_data_out;
    logic          ram_write_enable, ram_read_request, ram_read_ack;
    logic          ram_rdy, ram_rd_data_pres;
    logic [25:0]   ram_max_address;
    logic [15:0]   stat_writes, stat_reads, stat_timeouts;

    typedef struct { logic err; logic [DW-1:0] rdata; int cycle; } resp_t;
    typedef struct { logic wr; logic [25:0] addr; logic [DW-1:0] data; int cycle; } strb_t;
    typedef struct { logic [25:0] addr; logic [DW-1:0] data; } fifo_t;

    resp_t         resp_q[$];
    strb_t         strb_q[$];
    fifo_t         rd_fifo[$];
    logic [DW-1:0] ref_mem [logic [25:0]];
    logic [DW-1:0] ram_mem [logic [25:0]];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int cur_delay = NEVER;
    int pend_cycle = -1;
    logic [25:0] pend_addr = '0;
    int n_presented = 0, n_acked = 0;
    int exp_writes = 0, exp_reads = 0, exp_tmo = 0;

    ram_client_ctrl #(.DATA_BYTE_WIDTH(2), .RD_TIMEOUT(RDT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_enable(ram_write_enable), .ram_read_request(ram_read_request),
        .ram_read_ack(ram_read_ack), .ram_data_out(ram_data_out), .ram_rdy(ram_rdy),
        .ram_rd_data_pres(ram_rd_data_pres), .ram_max_address(ram_max_address),
        .stat_writes(stat_writes), .stat_reads(stat_reads), .stat_timeouts(stat_timeouts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] stat_exp(input int n);
`ifdef RAM_CLIENT_STATS_EN
        return (n > 65535) ? 16'hFFFF : 16'(n);
`else
        return 16'd0 + 16'(n & 0);
`endif
    endfunction

    // Reference model: predicted strobe and response for a request accepted in cycle t.
    function automatic void expect_accept(input int t, input logic wr, input logic [25:0] a,
                                          input logic [DW-1:0] d, input int dly);
        resp_t r;
        strb_t s;
        s.wr = wr; s.addr = a; s.data = d; s.cycle = t + 1;
        r.err = 1'b1; r.rdata = '0; r.cycle = t + 1;
        if (a > MAX_ADDR) begin
            r.cycle = t + 1;
        end else if (wr) begin
            strb_q.push_back(s);
            ref_mem[a] = d;
            exp_writes++;
            r.err = 1'b0; r.cycle = t + 2;
        end else begin
            s.data = '0;
            strb_q.push_back(s);
            if (dly != NEVER && dly <= RDT) begin
                r.err   = 1'b0;
                r.rdata = ref_mem.exists(a) ? ref_mem[a] : '0;
                r.cycle = t + dly + 3;
                exp_reads++;
            end else begin
                r.cycle = t + RDT + 2;
                exp_tmo++;
            end
        end
        resp_q.push_back(r);
    endfunction

    // Called at a falling edge; returns one falling edge after the handshake.
    task automatic issue(input logic wr, input logic [25:0] a, input logic [DW-1:0] d, input int dly);
        int n;
        cur_delay = dly;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_wait", 64'(req_ready), 64'd1);
        end else begin
            expect_accept(cyc, wr, a, d, dly);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || pend_cycle >= 0 || rd_fifo.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("settle_timeout", 64'(n), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Wrapper model: stores writes, presents read data after cur_delay cycles, pops on read_ack.
    initial begin
        fifo_t e;
        ram_data_out = '0;
        ram_rd_data_pres = 1'b0;
        forever begin
            @(negedge clk);
            if (ram_write_enable) ram_mem[ram_address] = ram_data_in;
            if (ram_read_ack) begin
                check("ack_has_data", 64'(rd_fifo.size() > 0), 64'd1);
                if (rd_fifo.size() > 0) begin
                    check("ack_addr_stable", 64'(ram_address), 64'(rd_fifo[0].addr));
                    rd_fifo.delete(0);
                    n_acked++;
                end
            end
            if (ram_read_request && cur_delay != NEVER) begin
                pend_cycle = cyc + cur_delay;
                pend_addr  = ram_address;
            end
            if (pend_cycle == cyc) begin
                e.addr = pend_addr;
                e.data = ram_mem.exists(pend_addr) ? ram_mem[pend_addr] : '0;
                rd_fifo.push_back(e);
                pend_cycle = -1;
                n_presented++;
            end
            ram_rd_data_pres = rd_fifo.size() > 0;
            ram_data_out     = (rd_fifo.size() > 0) ? rd_fifo[0].data : '0;
        end
    end

    // Monitor: pops the scoreboard on every response and every RAM strobe.
    initial begin
        resp_t r;
        strb_t s;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_resp: got resp_valid=1 err=%0b, expected none (cycle %0d)",
                             resp_err, cyc);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_err", 64'(resp_err), 64'(r.err));
                    check("resp_rdata", 64'(resp_rdata), 64'(r.rdata));
                    check("resp_cycle", 64'(cyc), 64'(r.cycle));
                end
            end
            if (ram_write_enable && ram_read_request) begin
                check("strobe_overlap", 64'd1, 64'd0);
            end else if (ram_write_enable || ram_read_request) begin
                if (strb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_strobe: got we=%0b rr=%0b, expected none (cycle %0d)",
                             ram_write_enable, ram_read_request, cyc);
                end else begin
                    s = strb_q.pop_front();
                    check("strobe_kind", 64'(ram_write_enable), 64'(s.wr));
                    check("strobe_addr", 64'(ram_address), 64'(s.addr));
                    if (s.wr) check("strobe_wdata", 64'(ram_data_in), 64'(s.data));
                    check("strobe_cycle", 64'(cyc), 64'(s.cycle));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish by 500000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks0;
        logic [25:0] a;
        int k, dly;

        reset = 1'b0; ram_rdy = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; ram_max_address = MAX_ADDR;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({req_ready, resp_valid, resp_err, busy,
                               ram_write_enable, ram_read_request, ram_read_ack}), 64'd0);
        check("rst_data", 64'({resp_rdata, ram_address, ram_data_in}), 64'd0);

        // Calibration wait with a pending write, then the write of 0xBEEF to 0x10.
        reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 26'h10; req_wdata = 16'hBEEF;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (req_ready) n++;
        end
        check("init_ready_low", 64'(n), 64'd0);
        check("init_busy", 64'(busy), 64'd1);
        ram_rdy = 1'b1;
        n = 0;
        while (!req_ready && n < 2) begin
            @(negedge clk);
            n++;
        end
        check("rdy_to_ready", 64'(req_ready), 64'd1);
        if (req_ready) expect_accept(cyc, 1'b1, 26'h10, 16'hBEEF, NEVER);
        @(negedge clk);
        req_valid = 1'b0;
        settle();

        issue(1'b0, 26'h10, '0, 5);                   settle();
        acks0 = n_acked;
        issue(1'b0, 26'h20, '0, RDT + 4);             settle();
        check("flush_ack_count", 64'(n_acked - acks0), 64'd1);
        issue(1'b1, MAX_ADDR + 26'd1, 16'h5555, NEVER); settle();
        issue(1'b0, MAX_ADDR + 26'd1, '0, 1);          settle();
        issue(1'b1, MAX_ADDR, 16'h1234, NEVER);        settle();
        issue(1'b0, MAX_ADDR, '0, RDT);                settle();
        issue(1'b0, 26'h10, '0, 1);                    settle();
        issue(1'b0, 26'h10, '0, RDT + 1);              settle();

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            a = 26'($urandom_range(0, 15));
            if (k == 0) a = MAX_ADDR + 26'd1 + 26'($urandom_range(0, 3));
            else if (k == 1) a = MAX_ADDR;
            dly = $urandom_range(1, RDT);
            if ($urandom_range(0, 5) == 0)
                dly = ($urandom_range(0, 1) == 1) ? NEVER : RDT + $urandom_range(1, 3);
            issue($urandom_range(0, 1) == 1, a, 16'($urandom), dly);
            settle();
        end
        check("stat_writes_mid", 64'(stat_writes), 64'(stat_exp(exp_writes)));
        check("stat_reads_mid", 64'(stat_reads), 64'(stat_exp(exp_reads)));
        check("stat_tmo_mid", 64'(stat_timeouts), 64'(stat_exp(exp_tmo)));

        // Reset in the middle of a read wait aborts it with no response.
        issue(1'b0, 26'h10, '0, NEVER);
        repeat (2) @(negedge clk);
        reset = 1'b0; ram_rdy = 1'b0;
        @(negedge clk);
        resp_q.delete(); strb_q.delete();
        exp_writes = 0; exp_reads = 0; exp_tmo = 0;
        check("midrst_ctrl", 64'({req_ready, resp_valid, resp_err, busy,
                                  ram_write_enable, ram_read_request, ram_read_ack}), 64'd0);
        check("midrst_data", 64'({resp_rdata, ram_address, ram_data_in}), 64'd0);
        check("midrst_stats", 64'({stat_writes, stat_reads, stat_timeouts}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_init", 64'({busy, req_ready}), 64'b10);
        ram_rdy = 1'b1;

        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 26'(i + 4), 16'hA000 + 16'(i), NEVER);
            settle();
        end
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, 26'(i + 4), '0, 3);
            settle();
        end

        check("stat_writes", 64'(stat_writes), 64'(stat_exp(3)));
        check("stat_reads", 64'(stat_reads), 64'(stat_exp(2)));
        check("stat_timeouts", 64'(stat_timeouts), 64'(stat_exp(0)));
        check("resp_q_empty", 64'(resp_q.size()), 64'd0);
        check("strb_q_empty", 64'(strb_q.size()), 64'd0);
        check("all_data_acked", 64'(n_acked), 64'(n_presented));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
